// File: rtl/register_scoreboard_pkg.sv
// Shared types and sizing for the register scoreboard.
// Optional feature macro: SCOREBOARD_BYPASS_EN.
package register_scoreboard_pkg;

    localparam int NUM_REGISTERS = 32;
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
    localparam int COUNT_WIDTH = 2;
    localparam int INFLIGHT_WIDTH = REGISTER_INDEXING_WIDTH + COUNT_WIDTH;

    typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;
    typedef logic [COUNT_WIDTH-1:0] pend_count_t;
    typedef logic [INFLIGHT_WIDTH-1:0] inflight_t;

    localparam pend_count_t COUNT_MAX = '1;

endpackage

// File: rtl/register_scoreboard_if.sv
// Issue / writeback / flush bundle between decode and the scoreboard.
// Optional feature macro: SCOREBOARD_BYPASS_EN (no effect on this bundle).
interface register_scoreboard_if;
    import register_scoreboard_pkg::*;

    logic       issue_valid;
    reg_index_t issue_rs1;
    logic       issue_rs1_used;
    reg_index_t issue_rs2;
    logic       issue_rs2_used;
    reg_index_t issue_rd;
    logic       issue_rd_en;
    logic       stall_issue;
    logic       wb_activate;
    reg_index_t wb_register;
    logic       flush;

    modport master (
        output issue_valid, issue_rs1, issue_rs1_used,
        output issue_rs2, issue_rs2_used, issue_rd, issue_rd_en,
        output wb_activate, wb_register, flush,
        input  stall_issue
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_used,
        input  issue_rs2, issue_rs2_used, issue_rd, issue_rd_en,
        input  wb_activate, wb_register, flush,
        output stall_issue
    );

endinterface

// File: rtl/scoreboard_counter.sv
// Pending-write counter for one architectural register.
// Optional feature macro: SCOREBOARD_BYPASS_EN (no effect here).
module scoreboard_counter
    import register_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        inc,
    input  logic        dec,
    output pend_count_t count
);

    // Simultaneous inc/dec cancel; decrement at zero is a stale writeback.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (inc && !dec && count != COUNT_MAX) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/register_scoreboard.sv
// In-flight destination tracker; stalls issue on RAW hazards and full counters.
// Optional feature macro: SCOREBOARD_BYPASS_EN enables same-cycle writeback bypass.
module register_scoreboard
    import register_scoreboard_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    register_scoreboard_if.slave     sb,
    output logic [NUM_REGISTERS-1:0] busy,
    output inflight_t                inflight_count
);

    logic [NUM_REGISTERS-1:0][COUNT_WIDTH-1:0] cnt;

    pend_count_t rs1_cnt;
    pend_count_t rs2_cnt;
    pend_count_t rd_cnt;
    pend_count_t wb_cnt;
    logic        rs1_byp;
    logic        rs2_byp;
    logic        rs1_haz;
    logic        rs2_haz;
    logic        dst_full;
    logic        issue_fire;
    logic        inc_en;
    logic        retire;
    logic        dec_eff;

    assign cnt[0] = '0;

    for (genvar i = 1; i < NUM_REGISTERS; i++) begin : g_cnt
        scoreboard_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .flush (sb.flush),
            .inc   (inc_en && sb.issue_rd == reg_index_t'(i)),
            .dec   (retire && sb.wb_register == reg_index_t'(i)),
            .count (cnt[i])
        );
    end

    always_comb begin
        rs1_cnt = cnt[sb.issue_rs1];
        rs2_cnt = cnt[sb.issue_rs2];
        rd_cnt  = cnt[sb.issue_rd];
        wb_cnt  = cnt[sb.wb_register];
        retire  = sb.wb_activate && sb.wb_register != '0;
`ifdef SCOREBOARD_BYPASS_EN
        rs1_byp = retire && sb.wb_register == sb.issue_rs1 && rs1_cnt == 1;
        rs2_byp = retire && sb.wb_register == sb.issue_rs2 && rs2_cnt == 1;
`else
        rs1_byp = 1'b0;
        rs2_byp = 1'b0;
`endif
        rs1_haz = sb.issue_rs1_used && sb.issue_rs1 != '0
                  && rs1_cnt != '0 && !rs1_byp;
        rs2_haz = sb.issue_rs2_used && sb.issue_rs2 != '0
                  && rs2_cnt != '0 && !rs2_byp;
        dst_full = sb.issue_rd_en && sb.issue_rd != '0
                   && rd_cnt == COUNT_MAX;
        sb.stall_issue = rst || sb.flush
                         || (sb.issue_valid && (rs1_haz || rs2_haz || dst_full));
        issue_fire = sb.issue_valid && !sb.stall_issue;
        inc_en = issue_fire && sb.issue_rd_en && sb.issue_rd != '0;
        // Retire at zero only counts when it cancels a same-register issue.
        dec_eff = retire && (wb_cnt != '0
                  || (inc_en && sb.issue_rd == sb.wb_register));
    end

    always_comb begin
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            busy[i] = cnt[i] != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            inflight_count <= '0;
        end else if (inc_en && !dec_eff) begin
            inflight_count <= inflight_count + 1'b1;
        end else if (dec_eff && !inc_en) begin
            inflight_count <= inflight_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed vector bench for register_scoreboard.
// Honours SCOREBOARD_BYPASS_EN for the same-cycle writeback cases.
module tb_register_scoreboard;
    import register_scoreboard_pkg::*;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit          v;
        int          rs1;
        bit          u1;
        int          rs2;
        bit          u2;
        int          rd;
        bit          en;
        bit          wa;
        int          wr;
        bit          fl;
        bit          st;
        logic [31:0] bz;
        int          ct;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_REGISTERS-1:0] busy;
    inflight_t inflight_count;

    register_scoreboard_if bus ();

    register_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .sb             (bus.slave),
        .busy           (busy),
        .inflight_count (inflight_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vq[$];

    function automatic vec_t mk(bit v, int rs1, bit u1, int rs2, bit u2,
                                int rd, bit en, bit wa, int wr, bit fl,
                                bit st, logic [31:0] bz, int ct);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.en = en; t.wa = wa; t.wr = wr; t.fl = fl;
        t.st = st; t.bz = bz; t.ct = ct;
        return t;
    endfunction

    task automatic drive(vec_t t);
        bus.issue_valid    = t.v;
        bus.issue_rs1      = reg_index_t'(t.rs1);
        bus.issue_rs1_used = t.u1;
        bus.issue_rs2      = reg_index_t'(t.rs2);
        bus.issue_rs2_used = t.u2;
        bus.issue_rd       = reg_index_t'(t.rd);
        bus.issue_rd_en    = t.en;
        bus.wb_activate    = t.wa;
        bus.wb_register    = reg_index_t'(t.wr);
        bus.flush          = t.fl;
    endtask

    task automatic check(string nm, bit st, logic [31:0] bz, int ct);
        n_cmp += 3;
        if (bus.stall_issue !== st) begin
            n_bad++;
            $display("FAIL %s stall got %0b want %0b", nm, bus.stall_issue, st);
        end
        if (busy !== bz) begin
            n_bad++;
            $display("FAIL %s busy got %h want %h", nm, busy, bz);
        end
        if (int'(inflight_count) != ct) begin
            n_bad++;
            $display("FAIL %s count got %0d want %0d", nm, inflight_count, ct);
        end
    endtask

    initial begin
        // v rs1 u1 rs2 u2 rd en wa wr fl | stall busy count (state before edge)
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 0, 0,0, 0, 32'h0,    0));
        vq.push_back(mk(1, 0,0, 0,0,  5,1, 0, 0,0, 0, 32'h0,    0));
        vq.push_back(mk(1, 5,1, 0,0,  6,1, 0, 0,0, 1, 32'h20,   1));
        vq.push_back(mk(1, 5,1, 0,0,  0,0, 1, 5,0, !BYP, 32'h20, 1));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 0, 0,0, 0, 32'h0,    0));
        vq.push_back(mk(1, 0,0, 0,0,  7,1, 0, 0,0, 0, 32'h0,    0));
        vq.push_back(mk(1, 0,0, 0,0,  7,1, 0, 0,0, 0, 32'h80,   1));
        vq.push_back(mk(1, 0,0, 0,0,  7,1, 0, 0,0, 0, 32'h80,   2));
        vq.push_back(mk(1, 0,0, 0,0,  7,1, 0, 0,0, 1, 32'h80,   3));
        vq.push_back(mk(1, 0,0, 0,0,  7,1, 1, 7,0, 1, 32'h80,   3));
        vq.push_back(mk(1, 0,0, 0,0,  7,1, 0, 0,0, 0, 32'h80,   2));
        vq.push_back(mk(1, 0,0, 7,1,  9,1, 0, 0,0, 1, 32'h80,   3));
        vq.push_back(mk(1, 0,0, 0,0,  9,1, 0, 0,0, 0, 32'h80,   3));
        vq.push_back(mk(1, 0,0, 0,0,  9,1, 1, 9,0, 0, 32'h280,  4));
        vq.push_back(mk(1, 0,1, 0,0,  0,1, 1, 0,0, 0, 32'h280,  4));
        vq.push_back(mk(0, 9,1, 0,0,  0,0, 0, 0,0, 0, 32'h280,  4));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 1, 9,0, 0, 32'h280,  4));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 1, 7,0, 0, 32'h80,   3));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 1, 7,0, 0, 32'h80,   2));
        vq.push_back(mk(1, 7,1, 0,0,  0,0, 1, 7,0, !BYP, 32'h80, 1));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 1, 7,0, 0, 32'h0,    0));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 0, 0,0, 0, 32'h0,    0));
        vq.push_back(mk(1, 0,0, 0,0,  3,1, 0, 0,0, 0, 32'h0,    0));
        vq.push_back(mk(1, 0,0, 0,0,  4,1, 0, 0,0, 0, 32'h8,    1));
        vq.push_back(mk(1, 0,0, 0,0, 10,1, 1, 3,1, 1, 32'h18,   2));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 1, 3,0, 0, 32'h0,    0));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 0, 0,0, 0, 32'h0,    0));
        vq.push_back(mk(1, 0,0, 0,0, 11,1, 0, 0,0, 0, 32'h0,    0));
        vq.push_back(mk(1, 0,0, 0,0, 12,1, 1,11,0, 0, 32'h800,  1));
        vq.push_back(mk(0, 0,0, 0,0,  0,0, 0, 0,0, 0, 32'h1000, 1));

        drive(mk(0, 0,0, 0,0, 0,0, 0,0,0, 0, 32'h0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.issue_valid = 1'b1;
        bus.issue_rd = reg_index_t'(5);
        bus.issue_rd_en = 1'b1;
        @(negedge clk);
        check("reset", 1'b1, 32'h0, 0);

        foreach (vq[i]) begin
            @(posedge clk);
            #1 rst = 1'b0;
            drive(vq[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].bz, vq[i].ct);
        end

        // Reset mid-operation with x12 pending and an issue offered.
        @(posedge clk);
        #1 drive(mk(1, 0,0, 0,0, 13,1, 0,0,0, 0, 32'h0, 0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", 1'b1, 32'h1000, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(mk(0, 0,0, 0,0, 0,0, 0,0,0, 0, 32'h0, 0));
        @(negedge clk);
        check("rst_after", 1'b0, 32'h0, 0);

        // Reset together with flush and a write: reset still clears.
        @(posedge clk);
        #1 drive(mk(1, 0,0, 0,0, 14,1, 0,0,1, 0, 32'h0, 0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_flush", 1'b1, 32'h0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(mk(0, 0,0, 0,0, 0,0, 0,0,0, 0, 32'h0, 0));
        @(negedge clk);
        check("rst_flush_after", 1'b0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
